// File: rtl/wb_pkg.sv
// Shared definitions for the writeback port arbiter: default widths,
// the hard-wired zero register, and the 1-bit grant / pointer encoding.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Architectural $0: accepted like any other target but never written.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Grant index. Also used as the round-robin priority pointer:
  // the pointer holds the port that wins the next contended cycle.
  typedef enum logic {
    GNT_P0 = 1'b0,
    GNT_P1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Readys are combinational from the
// valids and the priority pointer; the pointer moves to the other port
// after every accepted transfer, so a lone requester is served every
// cycle and contending requesters alternate.
module rr_arb2
  import wb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_ready0,
  output logic o_ready1,
  output gnt_e o_gnt
);

  gnt_e r_ptr;

  // Grant: an uncontested requester always wins; under contention the pointer decides.
  always_comb begin
    o_ready0 = i_valid0 & (~i_valid1 | (r_ptr == GNT_P0));
    o_ready1 = i_valid1 & (~i_valid0 | (r_ptr == GNT_P1));
    o_gnt    = o_ready1 ? GNT_P1 : GNT_P0;
  end

  // Pointer: favour the other port after a transfer, hold when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_ptr <= GNT_P0;
    else if (o_ready0) r_ptr <= GNT_P1;
    else if (o_ready1) r_ptr <= GNT_P0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port shared between the ALU path (port 0, rt/rd
// selected by RegDest) and the load / multi-cycle path (port 1).
// One registered write per accepted request, one cycle after acceptance.
// Writes to $0 complete their handshake but never assert wr_en.
// Optional: define WB_CONFLICT_CNT_EN to add the 16-bit saturating
// conflict_cnt output counting cycles where both ports request.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid0,
  output logic              ready0,
  input  logic              reg_dest0,
  input  logic [ADDR_W-1:0] rt0,
  input  logic [ADDR_W-1:0] rd0,
  input  logic [DATA_W-1:0] data0,
  input  logic              valid1,
  output logic              ready1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  gnt_e              w_gnt;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr0;
  logic [ADDR_W-1:0] w_eff_addr;
  logic [DATA_W-1:0] w_eff_data;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  rr_arb2 u_arb (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid0 (valid0),
    .i_valid1 (valid1),
    .o_ready0 (ready0),
    .o_ready1 (ready1),
    .o_gnt    (w_gnt)
  );

  // Effective destination and data of the granted port.
  always_comb begin
    w_xfer     = ready0 | ready1;
    w_addr0    = reg_dest0 ? rd0 : rt0;
    w_eff_addr = (w_gnt == GNT_P1) ? addr1 : w_addr0;
    w_eff_data = (w_gnt == GNT_P1) ? data1 : data0;
  end

  // Write-port register: capture on transfer, suppress enable for $0,
  // drop enable on idle cycles while address/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_xfer) begin
      r_wr_en   <= (w_eff_addr != ADDR_W'(REG_ZERO));
      r_wr_addr <= w_eff_addr;
      r_wr_data <= w_eff_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;

  // Count contended cycles (one side stalled), saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_conflict_cnt <= '0;
    else if (valid0 && valid1 && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: each cycle the expected write is
// pushed when inputs are driven and popped after the following edge.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid0, reg_dest0, valid1;
  logic [AW-1:0] rt0, rd0, addr1;
  logic [DW-1:0] data0, data1;
  logic          ready0, ready1, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0]   conflict_cnt;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid0       (valid0),
    .ready0       (ready0),
    .reg_dest0    (reg_dest0),
    .rt0          (rt0),
    .rd0          (rd0),
    .data0        (data0),
    .valid1       (valid1),
    .ready1       (ready1),
    .addr1        (addr1),
    .data1        (data1),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic          m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = 0;
    sb_q.delete();
  endtask

  task automatic drive(input logic v0, input logic rdst, input logic [AW-1:0] t0,
                       input logic [AW-1:0] d0, input logic [DW-1:0] x0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] x1);
    valid0 = v0; reg_dest0 = rdst; rt0 = t0; rd0 = d0; data0 = x0;
    valid1 = v1; addr1 = a1; data1 = x1;
  endtask

  // One cycle: inputs already driven at posedge+1. Check readys mid-cycle,
  // push the expected write, then pop and compare after the edge.
  task automatic cycle();
    logic          e0, e1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    wr_t           w;
    #3;
    e0 = valid0 & (!valid1 | (m_ptr == 1'b0));
    e1 = valid1 & (!valid0 | (m_ptr == 1'b1));
    chk("ready0", 64'(ready0), 64'(e0));
    chk("ready1", 64'(ready1), 64'(e1));
    ea = '0;
    ed = '0;
    if (e0) begin
      ea = reg_dest0 ? rd0 : rt0;
      ed = data0;
    end else if (e1) begin
      ea = addr1;
      ed = data1;
    end
    if (e0 | e1) begin
      w.en   = (ea != '0);
      w.addr = ea;
      w.data = ed;
      m_addr = ea;
      m_data = ed;
      m_ptr  = e0 ? 1'b1 : 1'b0;
    end else begin
      w.en   = 1'b0;
      w.addr = m_addr;
      w.data = m_data;
    end
    if (valid0 && valid1 && m_cnt < 65535) m_cnt++;
    sb_q.push_back(w);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
    end else begin
      w = sb_q.pop_front();
      chk("wr_en",   64'(wr_en),   64'(w.en));
      chk("wr_addr", 64'(wr_addr), 64'(w.addr));
      chk("wr_data", 64'(wr_data), 64'(w.data));
    end
`ifdef WB_CONFLICT_CNT_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_wr_en",   64'(wr_en),   64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    rst = 1'b0;

    // Port 0 alone: rd then rt selection.
    drive(1, 1, 5'd3, 5'd9, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    chk("p0_rd_addr", 64'(wr_addr), 64'(9));
    drive(1, 0, 5'd3, 5'd9, 32'hCAFEF00D, 0, 0, 0);
    cycle();
    chk("p0_rt_addr", 64'(wr_addr), 64'(3));

    // Reset mid-traffic (pointer currently favours port 1): async clear.
    drive(1, 1, 5'd3, 5'd12, 32'h11112222, 0, 0, 0);
    rst = 1'b1;
    #2;
    chk("async_wr_en",   64'(wr_en),   64'(0));
    chk("async_wr_addr", 64'(wr_addr), 64'(0));
    chk("async_wr_data", 64'(wr_data), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Contention from reset: expect P0,P1,P0,P1 -> 4,7,4,7, stalled data unchanged.
    drive(1, 1, 5'd2, 5'd4, 32'hA0A0A0A0, 1, 5'd7, 32'hB1B1B1B1);
    cycle();
    chk("cont0_addr", 64'(wr_addr), 64'(4));
    cycle();
    chk("cont1_addr", 64'(wr_addr), 64'(7));
    chk("cont1_data", 64'(wr_data), 64'(32'hB1B1B1B1));
    cycle();
    cycle();

    // $0 from port 1 alone: handshake completes, no write, pointer to port 0.
    drive(0, 0, 0, 0, 0, 1, 5'd0, 32'h1234);
    cycle();
    chk("zero_wr_en", 64'(wr_en), 64'(0));
    drive(1, 1, 5'd1, 5'd20, 32'h55AA55AA, 1, 5'd21, 32'h66BB66BB);
    cycle();
    chk("after_zero_addr", 64'(wr_addr), 64'(20));

    // Single transfer then idle: one-cycle pulse, address/data hold.
    drive(0, 0, 0, 0, 0, 1, 5'd30, 32'h0BADCAFE);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_hold_addr", 64'(wr_addr), 64'(30));

    // Random traffic, requesters holding stalled requests stable.
    for (int i = 0; i < 40; i++) begin
      if (!((valid0 && !ready0) || (valid1 && !ready1)) || ($urandom_range(0, 3) == 0)) begin
        drive($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom), AW'($urandom),
              $urandom, $urandom_range(0, 1), AW'($urandom), $urandom);
      end
      cycle();
    end

`ifdef WB_CONFLICT_CNT_EN
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("cnt_reset", 64'(conflict_cnt), 64'(0));
    drive(1, 1, 5'd1, 5'd2, 32'h1, 1, 5'd3, 32'h2);
    for (int i = 0; i < 10; i++) cycle();
    chk("cnt_ten", 64'(conflict_cnt), 64'(10));
    for (int i = 0; i < 65530; i++) @(posedge clk);
    #1;
    chk("cnt_sat", 64'(conflict_cnt), 64'(16'hFFFF));
    @(posedge clk);
    #1;
    chk("cnt_sat_hold", 64'(conflict_cnt), 64'(16'hFFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
